// File: rtl/sprite_fetch_arbiter_if.sv
// Sprite fetch arbiter bus bundle.
// Groups the requester handshake (req/mirror/gnt/done), the combinational
// sprite ROM port (rom_addr/rom_color) and the pixel stream (pix_*).
//   master : the arbiter side (drives gnt, done, rom_addr, pix_* outputs)
//   slave  : the environment side (requesters, ROM, pixel consumer)
// Pixel handshake: a pixel transfers on every rising clock edge where
// pix_valid and pix_ready are both high; while pix_valid is high and
// pix_ready is low, every pix_* signal and rom_addr holds its value.
interface sprite_fetch_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  mirror;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [8:0]  rom_addr;
    logic [11:0] rom_color;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pix_color;
    logic [4:0]  pix_x;
    logic [4:0]  pix_y;
    logic        pix_transp;
    logic        pix_last;

    modport master (
        input  req, mirror, rom_color, pix_ready,
        output gnt, done, rom_addr, pix_valid, pix_color, pix_x, pix_y,
               pix_transp, pix_last
    );

    modport slave (
        output req, mirror, rom_color, pix_ready,
        input  gnt, done, rom_addr, pix_valid, pix_color, pix_x, pix_y,
               pix_transp, pix_last
    );
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Sprite fetch arbiter.
// Two requesters compete for one combinational sprite ROM. The winner gets
// a burst that streams every pixel of an SPR_W x SPR_H sprite in screen
// order, optionally horizontally flipped, through a valid/ready pixel port.
// Ports:
//   Clk       : system clock, rising edge
//   Reset_n   : asynchronous active-low reset
//   bus       : sprite_fetch_arbiter_if.master (requests, ROM, pixel stream)
//   state_dbg : current FSM state (0 = IDLE, 1 = STREAM)
module sprite_fetch_arbiter #(
    parameter int          SPR_W  = 21,
    parameter int          SPR_H  = 21,
    parameter logic [11:0] TRANSP = 12'h808
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    sprite_fetch_arbiter_if.master bus,
    output logic                   state_dbg
);
    localparam logic [4:0] X_MAX    = 5'(SPR_W - 1);
    localparam logic [4:0] Y_MAX    = 5'(SPR_H - 1);
    localparam logic [8:0] ROW_STEP = 9'(SPR_W);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       mir_q, mir_d;
    logic [4:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic [8:0] rowbase_q, rowbase_d;
    logic       last_q, last_d;   // index of the requester granted last
    logic [1:0] done_q, done_d;

    logic       win;
    logic       xfer;
    logic       is_last;
    logic [4:0] col;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            mir_q     <= 1'b0;
            x_q       <= 5'd0;
            y_q       <= 5'd0;
            rowbase_q <= 9'd0;
            last_q    <= 1'b1;     // requester 0 wins the first contest
            done_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            mir_q     <= mir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rowbase_q <= rowbase_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    assign xfer    = (state_q == STREAM) && bus.pix_ready;
    assign is_last = (x_q == X_MAX) && (y_q == Y_MAX);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        mir_d     = mir_q;
        x_d       = x_q;
        y_d       = y_q;
        rowbase_d = rowbase_q;
        last_d    = last_q;
        done_d    = 2'b00;
        win       = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    // Round-robin on contention, otherwise the sole requester.
                    win       = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                    gnt_d     = win ? 2'b10 : 2'b01;
                    mir_d     = bus.mirror[win];
                    x_d       = 5'd0;
                    y_d       = 5'd0;
                    rowbase_d = 9'd0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if ((bus.req & gnt_q) == 2'b00) begin
                    // Owner withdrew: drop the burst silently, no done.
                    state_d   = IDLE;
                    gnt_d     = 2'b00;
                    last_d    = gnt_q[1];
                    x_d       = 5'd0;
                    y_d       = 5'd0;
                    rowbase_d = 9'd0;
                end else if (xfer) begin
                    if (is_last) begin
                        state_d   = IDLE;
                        gnt_d     = 2'b00;
                        done_d    = gnt_q;
                        last_d    = gnt_q[1];
                        x_d       = 5'd0;
                        y_d       = 5'd0;
                        rowbase_d = 9'd0;
                    end else if (x_q == X_MAX) begin
                        x_d       = 5'd0;
                        y_d       = y_q + 5'd1;
                        rowbase_d = rowbase_q + ROW_STEP;
                    end else begin
                        x_d = x_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flip reads the row right-to-left; pix_x still reports screen column.
    assign col = mir_q ? (X_MAX - x_q) : x_q;

    assign bus.rom_addr   = rowbase_q + {4'b0000, col};
    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.pix_valid  = (state_q == STREAM);
    assign bus.pix_last   = (state_q == STREAM) && is_last;
    assign bus.pix_color  = bus.rom_color;
    assign bus.pix_transp = (bus.rom_color == TRANSP);
    assign bus.pix_x      = x_q;
    assign bus.pix_y      = y_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
module tb_sprite_fetch_arbiter;
    localparam int SPR_W = 21;
    localparam int SPR_H = 21;
    localparam int NPIX  = SPR_W * SPR_H;

    logic Clk;
    logic Reset_n;
    logic state_dbg;
    logic transp_en;
    int   rdy_mode;      // 0: always ready, 1: toggle, 2: random
    int   cyc;
    int   total;
    int   bad;
    int   n_xfer;
    int   n_transp;
    int   done_cnt;

    logic [21:0] exp_q[$];   // {gnt, addr, x, y, last}

    sprite_fetch_arbiter_if bus ();

    sprite_fetch_arbiter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .TRANSP(12'h808)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- ROM model ----------------
    function automatic logic [11:0] romf(input logic [8:0] a, input logic te);
        return (te && a == 9'd5) ? 12'h808 : {3'b101, a};
    endfunction

    assign bus.rom_color = romf(bus.rom_addr, transp_en);

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic [1:0] g, input logic mir);
        for (int y = 0; y < SPR_H; y++) begin
            for (int x = 0; x < SPR_W; x++) begin
                int a;
                a = y * SPR_W + (mir ? (SPR_W - 1 - x) : x);
                exp_q.push_back({g, 9'(a), 5'(x), 5'(y),
                                 (x == SPR_W - 1) && (y == SPR_H - 1)});
            end
        end
    endtask

    // ---------------- pixel ready driver ----------------
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                1:       bus.pix_ready = ~bus.pix_ready;
                2:       bus.pix_ready = 1'($urandom_range(0, 1));
                default: bus.pix_ready = 1'b1;
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [34:0] snap;
    logic [34:0] cur;
    logic        prev_stall;

    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_stall = 1'b0;
        end else begin
            cur = {bus.gnt, bus.rom_addr, bus.pix_color, bus.pix_x, bus.pix_y,
                   bus.pix_last, bus.pix_transp};
            if (prev_stall) begin
                chk("stall_valid", bus.pix_valid, 1);
                chk("stall_hold", cur, snap);
            end
            if (bus.pix_valid && bus.pix_ready) begin
                logic [21:0] e;
                logic [11:0] ec;
                chk("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    ec = romf(e[19:11], transp_en);
                    chk("gnt", bus.gnt, e[21:20]);
                    chk("rom_addr", bus.rom_addr, e[19:11]);
                    chk("pix_x", bus.pix_x, e[10:6]);
                    chk("pix_y", bus.pix_y, e[5:1]);
                    chk("pix_last", bus.pix_last, e[0]);
                    chk("pix_color", bus.pix_color, ec);
                    chk("pix_transp", bus.pix_transp, ec == 12'h808);
                end
                n_xfer++;
                if (bus.pix_transp) n_transp++;
            end
            if (bus.done != 2'b00) done_cnt++;
            prev_stall = bus.pix_valid && !bus.pix_ready;
            snap       = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input logic [1:0] exp_done, input logic [1:0] next_req,
                             input int budget, output int at);
        logic got;
        got = 1'b0;
        at  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (bus.done != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        at = cyc;
        chk("done_seen", got, 1);
        chk("done_val", bus.done, exp_done);
        chk("done_gnt_low", bus.gnt, 2'b00);
        chk("done_valid_low", bus.pix_valid, 0);
        #1;
        bus.req = next_req;
    endtask

    task automatic reset_pulse();
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        int t1;
        int base;
        int dc0;
        logic ok;
        total     = 0;
        bad       = 0;
        n_xfer    = 0;
        n_transp  = 0;
        done_cnt  = 0;
        cyc       = 0;
        rdy_mode  = 0;
        transp_en = 1'b0;
        prev_stall = 1'b0;
        bus.req    = 2'b00;
        bus.mirror = 2'b00;
        Reset_n    = 1'b0;

        // Reset state
        #3;
        chk("rst_gnt", bus.gnt, 2'b00);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_last", bus.pix_last, 0);
        chk("rst_done", bus.done, 2'b00);
        chk("rst_addr", bus.rom_addr, 9'd0);
        chk("rst_state", state_dbg, 0);
        repeat (2) @(posedge Clk);
        #2;
        Reset_n = 1'b1;

        // A: requester 0, no flip, always ready
        @(posedge Clk);
        #1;
        base = n_xfer;
        push_burst(2'b01, 1'b0);
        bus.req = 2'b01;
        t0 = cyc;
        @(negedge Clk);
        chk("a_pre_grant_valid", bus.pix_valid, 0);
        @(negedge Clk);
        chk("a_lat_valid", bus.pix_valid, 1);
        chk("a_lat_gnt", bus.gnt, 2'b01);
        chk("a_lat_state", state_dbg, 1);
        wait_done(2'b01, 2'b00, 1000, t1);
        chk("a_cycles", t1 - t0, 442);
        chk("a_xfers", n_xfer - base, NPIX);
        chk("a_q_empty", exp_q.size(), 0);
        @(negedge Clk);
        chk("a_done_pulse", bus.done, 2'b00);

        // B: requester 1, flipped; mirror/other req changes ignored mid-burst
        @(posedge Clk);
        #1;
        base = n_xfer;
        push_burst(2'b10, 1'b1);
        bus.mirror = 2'b10;
        bus.req    = 2'b10;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (bus.pix_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b_valid_seen", ok, 1);
        chk("b_first_addr", bus.rom_addr, 9'd20);
        chk("b_first_x", bus.pix_x, 5'd0);
        #1;
        bus.mirror = 2'b00;
        bus.req    = 2'b11;
        wait_done(2'b10, 2'b00, 1000, t1);
        chk("b_xfers", n_xfer - base, NPIX);
        chk("b_q_empty", exp_q.size(), 0);

        // C: both requesting from reset -> 01, 10, 01 with one idle gap
        reset_pulse();
        @(posedge Clk);
        #1;
        base = n_xfer;
        push_burst(2'b01, 1'b0);
        push_burst(2'b10, 1'b0);
        push_burst(2'b01, 1'b0);
        bus.req = 2'b11;
        wait_done(2'b01, 2'b11, 1000, t1);
        @(negedge Clk);
        chk("c_gnt2", bus.gnt, 2'b10);
        chk("c_valid2", bus.pix_valid, 1);
        wait_done(2'b10, 2'b11, 1000, t1);
        @(negedge Clk);
        chk("c_gnt3", bus.gnt, 2'b01);
        wait_done(2'b01, 2'b00, 1000, t1);
        chk("c_xfers", n_xfer - base, 3 * NPIX);
        chk("c_q_empty", exp_q.size(), 0);

        // D: pix_ready toggling every cycle
        @(posedge Clk);
        #1;
        rdy_mode = 1;
        base = n_xfer;
        push_burst(2'b01, 1'b0);
        bus.req = 2'b01;
        wait_done(2'b01, 2'b00, 2000, t1);
        chk("d_xfers", n_xfer - base, NPIX);
        chk("d_q_empty", exp_q.size(), 0);

        // E: random ready, transparent colour planted at address 5
        @(posedge Clk);
        #1;
        rdy_mode  = 2;
        transp_en = 1'b1;
        base = n_xfer;
        dc0  = n_transp;
        push_burst(2'b10, 1'b0);
        bus.req = 2'b10;
        wait_done(2'b10, 2'b00, 4000, t1);
        chk("e_xfers", n_xfer - base, NPIX);
        chk("e_transp_count", n_transp - dc0, 1);
        chk("e_q_empty", exp_q.size(), 0);
        #1;
        rdy_mode  = 0;
        transp_en = 1'b0;

        // F: requester 0 withdraws after 100 pixels; next contest goes to 1
        @(posedge Clk);
        #1;
        base = n_xfer;
        push_burst(2'b01, 1'b0);
        bus.req = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge Clk);
            #1;
            if (n_xfer - base >= 100) begin
                ok = 1'b1;
                break;
            end
        end
        chk("f_reach_100", ok, 1);
        dc0 = done_cnt;
        bus.req = 2'b00;
        @(posedge Clk);
        #1;
        exp_q.delete();
        push_burst(2'b10, 1'b0);
        bus.req = 2'b11;
        @(negedge Clk);
        chk("f_ab_gnt", bus.gnt, 2'b00);
        chk("f_ab_valid", bus.pix_valid, 0);
        chk("f_ab_done", bus.done, 2'b00);
        chk("f_ab_state", state_dbg, 0);
        @(negedge Clk);
        chk("f_rr_gnt", bus.gnt, 2'b10);
        chk("f_rr_valid", bus.pix_valid, 1);
        #1;
        chk("f_no_done", done_cnt, dc0);
        wait_done(2'b10, 2'b00, 1000, t1);
        chk("f_q_empty", exp_q.size(), 0);

        // G: reset pulsed mid-burst drops it; fresh arbitration required
        @(posedge Clk);
        #1;
        base = n_xfer;
        push_burst(2'b01, 1'b0);
        bus.req = 2'b01;
        repeat (50) @(posedge Clk);
        #1;
        dc0 = done_cnt;
        bus.req = 2'b00;
        Reset_n = 1'b0;
        #1;
        chk("g_rst_gnt", bus.gnt, 2'b00);
        chk("g_rst_valid", bus.pix_valid, 0);
        chk("g_rst_last", bus.pix_last, 0);
        chk("g_rst_done", bus.done, 2'b00);
        chk("g_rst_addr", bus.rom_addr, 9'd0);
        chk("g_rst_state", state_dbg, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(negedge Clk);
            chk("g_idle_valid", bus.pix_valid, 0);
        end
        chk("g_no_done", done_cnt, dc0);
        @(posedge Clk);
        #1;
        push_burst(2'b10, 1'b0);
        bus.req = 2'b10;
        @(negedge Clk);
        @(negedge Clk);
        chk("g_regrant_gnt", bus.gnt, 2'b10);
        chk("g_regrant_addr", bus.rom_addr, 9'd0);
        #1;
        bus.req = 2'b00;
        @(posedge Clk);
        #1;
        exp_q.delete();
        @(negedge Clk);
        chk("g_end_valid", bus.pix_valid, 0);
        chk("g_end_gnt", bus.gnt, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
